// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream handshake, instruction memory write port and loader status.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic loader_start;
  logic [DATA_W-1:0] loader_in_data;
  logic loader_in_valid;
  logic loader_in_ready;
  logic loader_wr_en;
  logic [ADDR_W-1:0] loader_wr_addr;
  logic [DATA_W-1:0] loader_wr_data;
  logic loader_cpu_hold;
  logic loader_busy;
  logic loader_done;
  logic loader_error;
  modport master (
    output loader_start, loader_in_data, loader_in_valid,
    input loader_in_ready, loader_wr_en, loader_wr_addr, loader_wr_data,
    input loader_cpu_hold, loader_busy, loader_done, loader_error
  );
  modport slave (
    input loader_start, loader_in_data, loader_in_valid,
    output loader_in_ready, loader_wr_en, loader_wr_addr, loader_wr_data,
    output loader_cpu_hold, loader_busy, loader_done, loader_error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: framed byte stream to sequential instruction memory writes with processor hold.
// INSTR_LOADER_CHECKSUM_EN adds a trailing mod-256 payload sum byte to the frame.
module instr_mem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH = 64
) (
  input logic loader_clk,
  input logic loader_rst,
  instr_mem_loader_if.slave bus
);
  localparam int CW = ADDR_W + 1;
`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  localparam state_t FIN = CSUM;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t st, nxt;
  logic [ADDR_W-1:0] addr, wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CW-1:0] cnt;
  logic rdy, acc, last, len_ok, wr_en, hold, done, error;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  assign rdy = st inside {LEN, DATA, CSUM};
`else
  assign rdy = st inside {LEN, DATA};
`endif
  assign acc = bus.loader_in_valid && rdy;
  assign last = cnt == CW'(1);
  assign len_ok = 32'(bus.loader_in_data) <= 32'(DEPTH);
  assign bus.loader_in_ready = rdy;
  assign bus.loader_busy = rdy;
  assign bus.loader_wr_en = wr_en;
  assign bus.loader_wr_addr = wr_addr;
  assign bus.loader_wr_data = wr_data;
  assign bus.loader_cpu_hold = hold;
  assign bus.loader_done = done;
  assign bus.loader_error = error;
  always_comb begin
    nxt = st;
    case (st)
      IDLE, DONE, ERR: nxt = bus.loader_start ? LEN : st;
      LEN: nxt = acc ? (len_ok ? DATA : ERR) : st;
      DATA: nxt = acc && last ? FIN : st;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM: nxt = acc ? (bus.loader_in_data == sum ? DONE : ERR) : st;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge loader_clk) begin
    if (loader_rst) begin
      st <= IDLE;
      addr <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      hold <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      st <= nxt;
      wr_en <= st == DATA && acc;
      if (st == DATA && acc) begin
        wr_addr <= addr;
        wr_data <= bus.loader_in_data;
        addr <= addr + ADDR_W'(1);
        cnt <= cnt - CW'(1);
      end
      // length 0 encodes a full-memory image
      if (st == LEN && acc)
        cnt <= bus.loader_in_data == '0 ? CW'(DEPTH) : CW'(bus.loader_in_data);
      if (nxt == LEN && st != LEN) begin
        addr <= '0;
        cnt <= '0;
        done <= 1'b0;
        error <= 1'b0;
        hold <= 1'b1;
      end
      if (nxt == DONE && st != DONE) begin
        done <= 1'b1;
        hold <= 1'b0;
      end
      if (nxt == ERR && st != ERR) error <= 1'b1;
    end
  end
`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge loader_clk) begin
    if (loader_rst || (nxt == LEN && st != LEN)) sum <= '0;
    else if (st == DATA && acc) sum <= sum + bus.loader_in_data;
  end
`endif
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer side of the processor's 64 x 8 instruction memory: accepts a framed byte stream over a valid/ready handshake and issues one write per payload byte to consecutive addresses starting at 0. While a load is in progress it asserts a hold line that the top level ORs into the processor's reset, so the program counter, instruction counter and decoders stay reset until the image is complete. Sits between an external byte source (host link or test bench) and the instruction memory write port.

## Interface
- `ADDR_W`, default 6: instruction memory address width; matches the {program counter, instruction counter} address.
- `DATA_W`, default 8: byte width of the stream and the memory word.
- `DEPTH`, default 64: words in memory, equal to 2**ADDR_W.
- `loader_clk` in 1: single clock, same as the processor main clock.
- `loader_rst` in 1: synchronous, active-high reset.
- `loader_start` in 1: single-cycle request to begin a load.
- `loader_in_data` in DATA_W: stream byte.
- `loader_in_valid` in 1: source has a byte on `loader_in_data`.
- `loader_in_ready` out 1: loader accepts the byte this cycle.
- `loader_wr_en` out 1: memory write strobe, one cycle per payload byte.
- `loader_wr_addr` out ADDR_W: write address.
- `loader_wr_data` out DATA_W: write data.
- `loader_cpu_hold` out 1: hold the processor in reset.
- `loader_busy` out 1: load in progress (states LEN, DATA, CSUM).
- `loader_done` out 1: last load completed successfully. Level signal.
- `loader_error` out 1: last load failed. Level signal.

## Operation
- Frame format: a length byte L, then the payload bytes, then (with checksum enabled) one checksum byte.
- Length encoding: L = 1..64 means L bytes. L = 0 means 64 bytes. L = 65..255 is an error.
- A byte transfers on a rising edge where `loader_in_valid && loader_in_ready`.
- `loader_in_ready` is a registered-state decode: high in LEN, DATA and CSUM, low in every other state.
- State machine states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR to LEN: when `loader_start` is high. On entry, clear the address counter, byte counter, running sum, `loader_done` and `loader_error`.
  - LEN to DATA: on an accepted length byte with a legal value. Latch the byte count.
  - LEN to ERR: on an accepted length byte in 65..255.
  - DATA: each accepted byte writes to the current address, adds to the running sum (mod 256) and increments the address.
  - DATA to CSUM (checksum enabled) or DONE (checksum disabled): on acceptance of the final payload byte.
  - CSUM to DONE: accepted byte equals the running sum.
  - CSUM to ERR: accepted byte differs from the running sum.
- `loader_start` while busy is ignored. It does not restart the load.
- An invalid or stalled source simply holds the state. There is no timeout.
- The address counter is ADDR_W bits wide. A 64-byte load ends at address 63, and the counter wrap is never used to write.
- `loader_cpu_hold`:
  - Set on the edge that enters LEN.
  - Cleared on entry to DONE.
  - Remains set in ERR, so the processor never runs a partial image, until the next successful load or reset.
- Reset mid-load: all state returns to IDLE on the next edge and no further writes are issued. Memory contents already written are left as-is.

## Timing
- Reset values:
  - state IDLE
  - `loader_in_ready` 0
  - `loader_wr_en` 0
  - `loader_wr_addr` 0
  - `loader_wr_data` 0
  - `loader_cpu_hold` 0
  - `loader_busy` 0
  - `loader_done` 0
  - `loader_error` 0
- `loader_start` at edge N: the state is LEN from N+1, and `loader_in_ready` and `loader_cpu_hold` are high in cycle N+1.
- Write latency: a payload byte accepted at edge N produces `loader_wr_en`=1 with its address and data during cycle N+1 (registered outputs). At most one write per cycle.
- Back-to-back: with valid held high, one byte per cycle is accepted, so a full 64-byte image takes 1 + 64 (+1) cycles after start.
- Final byte accepted at edge N: `loader_done` rises and `loader_cpu_hold` falls at N+1, the same cycle as the last `loader_wr_en`.
- `loader_error` rises the cycle after the offending byte.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN`
  - Defined: the frame carries a trailing checksum byte (mod-256 sum of the payload). A mismatch goes to ERR. CSUM state and the sum register are present.
  - Undefined: no checksum byte is expected. DATA goes directly to DONE after the last payload byte. CSUM state and the sum register are removed.

## Test plan
- Reset then idle: all outputs 0, `loader_in_ready` 0, and no writes regardless of `loader_in_valid`.
- Start, L=3, payload 8'h11, 8'h22, 8'h33, checksum 8'h66 (valid held high) -> writes (0,11), (1,22), (2,33) on consecutive cycles. `loader_done`=1 and `loader_cpu_hold`=0 the cycle after the checksum is accepted.
- Start, L=0, 64 bytes of value i at index i, checksum 8'hE0 -> 64 writes covering addresses 0..63, no write to address 0 after 63, then done.
- Start, L=2, payload 8'h01, 8'h02, checksum 8'h04 -> both writes issued, then `loader_error`=1, `loader_done`=0, `loader_cpu_hold` stays 1. Restarting with a correct frame clears the error.
- Start, L=8'h41 -> no writes, ERR the next cycle, `loader_in_ready` 0.
- Valid toggling every other cycle plus `loader_start` pulsed mid-DATA -> writes only on accepted bytes, addresses stay contiguous, start ignored. Asserting `loader_rst` after byte 2 returns all outputs to their reset values on the next cycle.
